player_action_fsm: RTL and testbench

PLAYER_ACTION_FSM -- requirements
Module: player_action_fsm

---
 rtl/fighter_pkg.sv | 19 +
 rtl/tick_edge_detect.sv | 27 ++
 rtl/player_action_fsm.sv | 123 ++++++++++++
 tb/tb_player_action_fsm.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fighter_pkg.sv
// Shared fighter definitions: action state encoding, counter width and
// default frame counts used by the action FSM, renderer and game logic.
package fighter_pkg;

    localparam int unsigned CNT_W               = 5;
    localparam int unsigned DEF_PUNCH_FRAMES    = 8;
    localparam int unsigned DEF_KICK_FRAMES     = 12;
    localparam int unsigned DEF_COOLDOWN_FRAMES = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MOVE_FWD  = 3'd1,
        ST_MOVE_BACK = 3'd2,
        ST_PUNCH     = 3'd3,
        ST_KICK      = 3'd4,
        ST_COOLDOWN  = 3'd5
    } action_state_t;

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector sampled only on frame ticks.
//   clk, rst_n : clock and async active-low reset
//   tick       : sample enable (one pulse per frame)
//   din        : level input
//   rise_c     : combinational; high when din is 1 now and was 0 at the last tick
module tick_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic din,
    output logic rise_c
);

    logic prev;

    // Previous-tick sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else if (tick) begin
            prev <= din;
        end
    end

    assign rise_c = din & ~prev;

endmodule

// File: rtl/player_action_fsm.sv
// Per-player action FSM: turns button levels into one-hot move/attack
// outputs for the sprite renderer, advancing once per video frame.
//   clk_65mhz, rst_n          : pixel clock, async active-low reset
//   frame_tick                : one-cycle pulse per frame; only cycle decisions happen
//   btn_punch/kick/fwd/back   : synchronized button levels
//   punch/kick/forwards/backwards : registered move outputs (at most one high)
//   busy                      : registered, high during attack and cooldown
module player_action_fsm
    import fighter_pkg::*;
#(
    parameter int unsigned PUNCH_FRAMES    = DEF_PUNCH_FRAMES,
    parameter int unsigned KICK_FRAMES     = DEF_KICK_FRAMES,
    parameter int unsigned COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
    input  logic clk_65mhz,
    input  logic rst_n,
    input  logic frame_tick,
    input  logic btn_punch,
    input  logic btn_kick,
    input  logic btn_fwd,
    input  logic btn_back,
    output logic punch,
    output logic kick,
    output logic forwards,
    output logic backwards,
    output logic busy
);

    localparam logic [CNT_W-1:0] PUNCH_LOAD = CNT_W'(PUNCH_FRAMES - 1);
    localparam logic [CNT_W-1:0] KICK_LOAD  = CNT_W'(KICK_FRAMES - 1);
    localparam bit               HAS_COOL   = (COOLDOWN_FRAMES != 0);
    localparam logic [CNT_W-1:0] COOL_LOAD  = HAS_COOL ? CNT_W'(COOLDOWN_FRAMES - 1) : '0;

    action_state_t    state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             punch_rise_c, kick_rise_c;

    tick_edge_detect u_punch_edge (
        .clk    (clk_65mhz),
        .rst_n  (rst_n),
        .tick   (frame_tick),
        .din    (btn_punch),
        .rise_c (punch_rise_c)
    );

    tick_edge_detect u_kick_edge (
        .clk    (clk_65mhz),
        .rst_n  (rst_n),
        .tick   (frame_tick),
        .din    (btn_kick),
        .rise_c (kick_rise_c)
    );

    // Next-state and frame counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE, ST_MOVE_FWD, ST_MOVE_BACK: begin
                cnt_nxt = '0;
                if (punch_rise_c) begin
                    state_nxt = ST_PUNCH;
                    cnt_nxt   = PUNCH_LOAD;
                end else if (kick_rise_c) begin
                    state_nxt = ST_KICK;
                    cnt_nxt   = KICK_LOAD;
                end else if (btn_fwd && !btn_back) begin
                    state_nxt = ST_MOVE_FWD;
                end else if (btn_back && !btn_fwd) begin
                    state_nxt = ST_MOVE_BACK;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_PUNCH, ST_KICK: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (HAS_COOL) begin
                    state_nxt = ST_COOLDOWN;
                    cnt_nxt   = COOL_LOAD;
                end else begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            ST_COOLDOWN: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and output registers; outputs load the decode of the
    // next state so they always match the state register.
    always_ff @(posedge clk_65mhz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            punch     <= 1'b0;
            kick      <= 1'b0;
            forwards  <= 1'b0;
            backwards <= 1'b0;
            busy      <= 1'b0;
        end else if (frame_tick) begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            punch     <= (state_nxt == ST_PUNCH);
            kick      <= (state_nxt == ST_KICK);
            forwards  <= (state_nxt == ST_MOVE_FWD);
            backwards <= (state_nxt == ST_MOVE_BACK);
            busy      <= (state_nxt == ST_PUNCH) || (state_nxt == ST_KICK)
                      || (state_nxt == ST_COOLDOWN);
        end
    end

endmodule

// File: tb/tb_player_action_fsm.sv
`timescale 1ns/1ps
module tb_player_action_fsm;

    logic clk_65mhz = 1'b0;
    logic rst_n = 1'b0;
    logic frame_tick = 1'b0;
    logic btn_punch = 1'b0, btn_kick = 1'b0, btn_fwd = 1'b0, btn_back = 1'b0;
    logic p0, k0, f0, b0, y0;
    logic p1, k1, f1, b1, y1;
    logic [4:0] act0, act1;

    int n_tests = 0;
    int n_fail  = 0;

    always #8 clk_65mhz = ~clk_65mhz;

    player_action_fsm dut (
        .clk_65mhz(clk_65mhz), .rst_n(rst_n), .frame_tick(frame_tick),
        .btn_punch(btn_punch), .btn_kick(btn_kick), .btn_fwd(btn_fwd), .btn_back(btn_back),
        .punch(p0), .kick(k0), .forwards(f0), .backwards(b0), .busy(y0)
    );

    player_action_fsm #(.PUNCH_FRAMES(1), .KICK_FRAMES(3), .COOLDOWN_FRAMES(0)) dut_fast (
        .clk_65mhz(clk_65mhz), .rst_n(rst_n), .frame_tick(frame_tick),
        .btn_punch(btn_punch), .btn_kick(btn_kick), .btn_fwd(btn_fwd), .btn_back(btn_back),
        .punch(p1), .kick(k1), .forwards(f1), .backwards(b1), .busy(y1)
    );

    assign act0 = {p0, k0, f0, b0, y0};
    assign act1 = {p1, k1, f1, b1, y1};

    // Reference model: an attack schedules a fixed plan of frames
    // (N attack frames, C cooldown frames, one forced idle frame) that
    // plays out ignoring buttons; otherwise buttons map straight to moves.
    // Codes: 0 idle, 1 punch, 2 kick, 3 cooldown, 4 forwards, 5 backwards.
    int plan [2][64];
    int plen [2];
    int phead[2];
    bit prev_p[2], prev_k[2];
    logic [4:0] exp_act[2];
    int pf[2] = '{8, 1};
    int kf[2] = '{12, 3};
    int cf[2] = '{4, 0};

    function automatic logic [4:0] code_vec(input int code);
        case (code)
            1:       return 5'b10001;
            2:       return 5'b01001;
            3:       return 5'b00001;
            4:       return 5'b00100;
            5:       return 5'b00010;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            plen[m] = 0; phead[m] = 0;
            prev_p[m] = 1'b0; prev_k[m] = 1'b0;
            exp_act[m] = 5'b0;
        end
    endtask

    task automatic model_step(input int m, input bit bp, input bit bk, input bit bf, input bit bb);
        bit pe, ke;
        int code, n, ac;
        pe = bp && !prev_p[m];
        ke = bk && !prev_k[m];
        prev_p[m] = bp;
        prev_k[m] = bk;
        if (phead[m] < plen[m]) begin
            code = plan[m][phead[m]];
            phead[m] = phead[m] + 1;
        end else if (pe || ke) begin
            n  = pe ? pf[m] : kf[m];
            ac = pe ? 1 : 2;
            plen[m] = 0;
            for (int i = 0; i < n; i++)     begin plan[m][plen[m]] = ac; plen[m]++; end
            for (int i = 0; i < cf[m]; i++) begin plan[m][plen[m]] = 3;  plen[m]++; end
            plan[m][plen[m]] = 0; plen[m]++;
            code = plan[m][0];
            phead[m] = 1;
        end else if (bf && !bb) begin
            code = 4;
        end else if (bb && !bf) begin
            code = 5;
        end else begin
            code = 0;
        end
        exp_act[m] = code_vec(code);
    endtask

    // Drive one frame tick with given buttons, then idle 'gap' cycles.
    task automatic do_tick(input bit bp, input bit bk, input bit bf, input bit bb, input int gap);
        @(negedge clk_65mhz);
        btn_punch = bp; btn_kick = bk; btn_fwd = bf; btn_back = bb;
        frame_tick = 1'b1;
        @(negedge clk_65mhz);
        frame_tick = 1'b0;
        model_step(0, bp, bk, bf, bb);
        model_step(1, bp, bk, bf, bb);
        repeat (gap) @(negedge clk_65mhz);
    endtask

    task automatic apply_reset();
        @(negedge clk_65mhz);
        rst_n = 1'b0;
        btn_punch = 0; btn_kick = 0; btn_fwd = 0; btn_back = 0;
        model_reset();
        repeat (2) @(negedge clk_65mhz);
        rst_n = 1'b1;
        @(negedge clk_65mhz);
    endtask

    task automatic test_reset();
        @(negedge clk_65mhz);
        rst_n = 1'b0;
        model_reset();
        #2;
        n_tests++;
        if (act0 !== 5'b0) begin n_fail++; $display("FAIL reset_dut0: got %b want %b", act0, 5'b0); end
        n_tests++;
        if (act1 !== 5'b0) begin n_fail++; $display("FAIL reset_dut1: got %b want %b", act1, 5'b0); end
        @(negedge clk_65mhz);
        rst_n = 1'b1;
        // Buttons held without any tick must not move the FSM.
        btn_fwd = 1'b1; btn_punch = 1'b1;
        repeat (5) @(negedge clk_65mhz);
        n_tests++;
        if (act0 !== 5'b0) begin n_fail++; $display("FAIL no_tick_hold: got %b want %b", act0, 5'b0); end
        apply_reset();
    endtask

    task automatic test_punch_hold();
        int pcount, bcount;
        pcount = 0; bcount = 0;
        apply_reset();
        for (int i = 1; i <= 15; i++) begin
            do_tick(1, 0, 0, 0, 1);
            pcount += int'(p0);
            bcount += int'(y0);
            n_tests++;
            if (act0 !== exp_act[0]) begin n_fail++; $display("FAIL punch_hold dut0 tick %0d: got %b want %b", i, act0, exp_act[0]); end
            n_tests++;
            if (act1 !== exp_act[1]) begin n_fail++; $display("FAIL punch_hold dut1 tick %0d: got %b want %b", i, act1, exp_act[1]); end
        end
        n_tests++;
        if (pcount !== 8) begin n_fail++; $display("FAIL punch_frames: got %0d want %0d", pcount, 8); end
        n_tests++;
        if (bcount !== 12) begin n_fail++; $display("FAIL punch_busy_frames: got %0d want %0d", bcount, 12); end
    endtask

    task automatic test_simultaneous();
        int kcount, bcount;
        kcount = 0; bcount = 0;
        apply_reset();
        do_tick(0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            do_tick(1, 1, 0, 0, 0);
            kcount += int'(k0);
            bcount += int'(y0);
            n_tests++;
            if (act0 !== exp_act[0]) begin n_fail++; $display("FAIL simult dut0 tick %0d: got %b want %b", i, act0, exp_act[0]); end
        end
        n_tests++;
        if (kcount !== 0) begin n_fail++; $display("FAIL simult_kick_frames: got %0d want %0d", kcount, 0); end
        n_tests++;
        if (bcount !== 12) begin n_fail++; $display("FAIL simult_busy_frames: got %0d want %0d", bcount, 12); end
    endtask

    task automatic test_fwd_back();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            do_tick(0, 0, 1, (i >= 3), 2);
            n_tests++;
            if (act0 !== exp_act[0]) begin n_fail++; $display("FAIL fwd_back dut0 tick %0d: got %b want %b", i, act0, exp_act[0]); end
            n_tests++;
            if (act0 !== ((i < 3) ? 5'b00100 : 5'b00000)) begin
                n_fail++; $display("FAIL fwd_back_fixed tick %0d: got %b want %b", i, act0, (i < 3) ? 5'b00100 : 5'b00000);
            end
        end
    endtask

    task automatic test_back_kick();
        int kcount;
        kcount = 0;
        apply_reset();
        do_tick(0, 0, 0, 1, 0);
        do_tick(0, 0, 0, 1, 0);
        n_tests++;
        if (act0 !== 5'b00010) begin n_fail++; $display("FAIL back_state: got %b want %b", act0, 5'b00010); end
        for (int i = 0; i < 16; i++) begin
            do_tick(0, 1, 0, 1, 0);
            kcount += int'(k0);
            if (i == 0) begin
                n_tests++;
                if ({k0, b0} !== 2'b10) begin n_fail++; $display("FAIL back_to_kick_switch: got %b want %b", {k0, b0}, 2'b10); end
            end
            n_tests++;
            if (act0 !== exp_act[0]) begin n_fail++; $display("FAIL back_kick dut0 tick %0d: got %b want %b", i, act0, exp_act[0]); end
            n_tests++;
            if (act1 !== exp_act[1]) begin n_fail++; $display("FAIL back_kick dut1 tick %0d: got %b want %b", i, act1, exp_act[1]); end
        end
        n_tests++;
        if (kcount !== 12) begin n_fail++; $display("FAIL kick_frames: got %0d want %0d", kcount, 12); end
    endtask

    task automatic test_fast_params();
        logic [2:0] want_p;
        want_p = 3'b101;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            do_tick((i != 1), 0, 0, 0, 0);
            n_tests++;
            if (p1 !== want_p[i]) begin n_fail++; $display("FAIL fast_punch tick %0d: got %b want %b", i, p1, want_p[i]); end
            n_tests++;
            if (act1 !== exp_act[1]) begin n_fail++; $display("FAIL fast dut1 tick %0d: got %b want %b", i, act1, exp_act[1]); end
        end
    endtask

    task automatic test_reset_mid_kick();
        apply_reset();
        for (int i = 0; i < 5; i++) do_tick(0, 1, 0, 0, 1);
        n_tests++;
        if (act0 !== 5'b01001) begin n_fail++; $display("FAIL kick_frame5: got %b want %b", act0, 5'b01001); end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (act0 !== 5'b0) begin n_fail++; $display("FAIL async_reset_kick: got %b want %b", act0, 5'b0); end
        @(negedge clk_65mhz);
        @(negedge clk_65mhz);
        rst_n = 1'b1;
        do_tick(0, 1, 0, 0, 0);
        n_tests++;
        if (act0 !== 5'b01001) begin n_fail++; $display("FAIL kick_after_reset dut0: got %b want %b", act0, 5'b01001); end
        n_tests++;
        if (act1 !== exp_act[1]) begin n_fail++; $display("FAIL kick_after_reset dut1: got %b want %b", act1, exp_act[1]); end
    endtask

    task automatic test_random();
        bit bp, bk, bf, bb;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            bp = ($urandom_range(0, 3) == 0);
            bk = ($urandom_range(0, 3) == 0);
            bf = ($urandom_range(0, 1) == 0);
            bb = ($urandom_range(0, 2) == 0);
            do_tick(bp, bk, bf, bb, $urandom_range(0, 2));
            n_tests++;
            if (act0 !== exp_act[0]) begin n_fail++; $display("FAIL random dut0 tick %0d: got %b want %b", i, act0, exp_act[0]); end
            n_tests++;
            if (act1 !== exp_act[1]) begin n_fail++; $display("FAIL random dut1 tick %0d: got %b want %b", i, act1, exp_act[1]); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_punch_hold();
        test_simultaneous();
        test_fwd_back();
        test_back_kick();
        test_fast_params();
        test_reset_mid_kick();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
